// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small TX FIFO; a byte accepted into an empty FIFO drives the start bit one edge later.
// Backpressure: tx_ready follows the registered FIFO count only, so a full FIFO refuses bytes even on a pop cycle.
module uart_tx #(
    parameter int BAUD_RATE   = 115200,
    parameter int CLK_VAL_MHZ = 50,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int BAUD_DIV = CLK_VAL_MHZ * 1000000 / BAUD_RATE;
    localparam int CW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int PW       = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [PW:0]   FULL_CNT  = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   baud_cnt, baud_nxt;
    logic [2:0]      bit_cnt, bit_nxt;
    logic [7:0]      shift, shift_nxt;
    logic            tx_nxt, busy_nxt;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic            push, pop;
    logic            baud_end;
    logic            fifo_nempty;

    assign tx_ready    = (fifo_count != FULL_CNT);
    assign push        = tx_valid && tx_ready;
    assign baud_end    = (baud_cnt == BAUD_LAST);
    assign fifo_nempty = (fifo_count != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (PW + 1)'(1);
                2'b01:   fifo_count <= fifo_count - (PW + 1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // pop is only raised with fifo_nempty, so the FIFO can never underflow
    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_end ? '0 : baud_cnt + CW'(1);
        bit_nxt   = bit_cnt;
        shift_nxt = shift;
        tx_nxt    = tx;
        busy_nxt  = tx_busy;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                baud_nxt = '0;
                tx_nxt   = 1'b1;
                busy_nxt = 1'b0;
                if (fifo_nempty) begin
                    pop       = 1'b1;
                    shift_nxt = mem[rd_ptr];
                    tx_nxt    = 1'b0;
                    busy_nxt  = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                if (baud_end) begin
                    tx_nxt    = shift[0];
                    bit_nxt   = '0;
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (baud_end) begin
                    if (bit_cnt == 3'd7) begin
                        tx_nxt    = 1'b1;
                        state_nxt = STOP;
                    end else begin
                        shift_nxt = {1'b0, shift[7:1]};
                        tx_nxt    = shift[1];
                        bit_nxt   = bit_cnt + 3'd1;
                    end
                end
            end
            STOP: begin
                if (baud_end) begin
                    if (fifo_nempty) begin
                        pop       = 1'b1;
                        shift_nxt = mem[rd_ptr];
                        tx_nxt    = 1'b0;
                        state_nxt = START;
                    end else begin
                        busy_nxt  = 1'b0;
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_cnt  <= bit_nxt;
            shift    <= shift_nxt;
            tx       <= tx_nxt;
            tx_busy  <= busy_nxt;
        end
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter, the send-side counterpart of the team's uart_rx; same frame format: 8N1, LSB first, idle-high line.
- Accepts bytes from the core over a valid/ready handshake into a small FIFO, then serialises them onto the tx pin.
- Sits between the CPU/MMIO UART register block and the board TX pin.
- Back-to-back bytes in the FIFO are sent with no idle gap between frames.

Parameters:
- BAUD_RATE, 115200, line rate in bits/s.
- CLK_VAL_MHZ, 50, clk frequency in MHz.
- FIFO_DEPTH, 4, TX FIFO entries; power of two, minimum 2.
- BAUD_DIV, CLK_VAL_MHZ*1000000/BAUD_RATE (integer floor), clk cycles per bit; derived, not overridden.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- tx_data  in  8  byte to send.
- tx_valid  in  1  tx_data is valid this cycle.
- tx_ready  out  1  FIFO can accept a byte; high when not full.
- tx  out  1  serial line out; idle high.
- tx_busy  out  1  high while a frame is on the line.
- fifo_count  out  clog2(FIFO_DEPTH)+1  bytes currently in the FIFO.

Behaviour:
- Reset (rst_n low, asynchronous): tx=1, tx_busy=0, fifo_count=0, tx_ready=1, FIFO pointers=0, state=IDLE, baud and bit counters=0.
  - Reset asserted mid-frame aborts the frame: tx goes high immediately and all queued bytes are discarded.
- Handshake:
  - A push occurs on a rising edge where tx_valid && tx_ready.
  - tx_ready = (fifo_count != FIFO_DEPTH), from registered count only.
  - When full, tx_ready=0 and tx_valid is ignored, even if a pop happens the same cycle.
  - tx_data need only be stable during the accepting cycle.
- FIFO: circular buffer with read and write pointers that wrap modulo FIFO_DEPTH.
  - A simultaneous push and pop leaves fifo_count unchanged.
  - A pop never occurs when the FIFO is empty.
- State machine IDLE -> START -> DATA -> STOP:
  - IDLE: tx=1, tx_busy=0. If fifo_count!=0: pop the head byte into the shift register, clear the baud counter, set tx<=0 and tx_busy<=1, go to START.
  - START: hold tx=0 for BAUD_DIV cycles. At the end, drive tx<=shift[0], clear the bit counter, go to DATA.
  - DATA: each bit is held BAUD_DIV cycles; bits go out LSB first (shift right). After bit 7 completes, drive tx<=1 and go to STOP.
  - STOP: hold tx=1 for BAUD_DIV cycles. At the end:
    - if fifo_count!=0: pop, tx<=0, go to START (tx_busy stays 1, no idle gap);
    - else: tx_busy<=0, go to IDLE.
- Baud counter: counts 0..BAUD_DIV-1 and wraps to 0 at each bit boundary.
  - Each bit lasts exactly BAUD_DIV cycles; one frame is exactly 10*BAUD_DIV cycles.
  - Counter width is sufficient for BAUD_DIV-1.
- Latency: a byte accepted at edge N into an empty FIFO with the block IDLE drives tx low at edge N+1.
- tx is a registered output and glitch-free.

Test Plan:
- Use CLK_VAL_MHZ=1, BAUD_RATE=250000 (BAUD_DIV=4). Reset, push 0xA5 once -> tx falls at edge N+1, then:
  - tx line sequence 0,1,0,1,0,0,1,0,1,1, each value held 4 cycles;
  - tx_busy high for exactly 40 cycles;
  - fifo_count goes 1 then 0.
- Push 0x00, 0xFF, 0x55 on consecutive cycles -> three contiguous frames (120 cycles), no high gap between stop and next start, tx_busy high throughout.
- Push 6 bytes, one per cycle, with tx_valid held high -> tx_ready drops once fifo_count=4; the extra byte is only accepted after a pop; all accepted bytes are transmitted in order and none is lost or duplicated.
- Pulse rst_n low during data bit 3 of a frame with 2 bytes queued -> tx=1 asynchronously, fifo_count=0, tx_busy=0; no further frame follows.
- With the FIFO full, drive tx_valid=1 at the same cycle STOP pops -> no push that cycle; fifo_count decrements by exactly 1.
- Loopback tx into uart_rx (same parameters) with bytes 0x00, 0x7E, 0x81, 0xFF -> the receiver reports the identical bytes.
